rq_to_r3_fsm: RTL and testbench



---
 rtl/rq_to_r3_fsm.sv | 166 ++++++++++++++++
 tb/tb_rq_to_r3_fsm.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rq_to_r3_fsm.sv
// Rq->R3 reducer: centre-lifts each coefficient mod Q, reduces mod 3, 4 cycles per coefficient.
// No backpressure; define RQ2R3_RANGE_CHECK_EN to flag RAM words >= Q on err.
module rq_to_r3_fsm #(
  parameter int Q  = 4591,
  parameter int AW = 11,
  parameter int DW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] degp,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] mem_output,
  output logic          write_enable,
  output logic [AW-1:0] wr_addr,
  output logic [1:0]    wr_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned   QM3  = Q % 3;
  localparam logic [DW-1:0] HALF = DW'((Q - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CALC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] i_r;
  logic [AW-1:0] deg_r;
  logic [AW-1:0] rd_addr_r;
  logic [AW-1:0] wr_addr_r;
  logic [DW-1:0] x_r;
  logic [1:0]    code_r;
  logic          more;

  // Values above (Q-1)/2 represent x-Q; shifting by Q changes the residue by -(Q mod 3).
  function automatic logic [1:0] rq_to_r3(input logic [DW-1:0] x);
    logic [1:0] r;
    logic [2:0] t;
    r = 2'(x % DW'(3));
    t = {1'b0, r} + 3'(3 - QM3);
    if (x > HALF) begin
      return (t >= 3'd3) ? 2'(t - 3'd3) : 2'(t);
    end
    return r;
  endfunction

  assign more = (i_r < deg_r);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rd_en        = 1'b0;
    write_enable = 1'b0;
    done         = 1'b0;
    busy         = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        rd_en     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        state_nxt = S_CALC;
      end
      S_CALC: begin
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        write_enable = 1'b1;
        state_nxt    = more ? S_READ : S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Address/data outputs only change on entry to their strobe state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_r       <= '0;
      deg_r     <= '0;
      rd_addr_r <= '0;
      wr_addr_r <= '0;
      x_r       <= '0;
      code_r    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            deg_r     <= degp;
            i_r       <= '0;
            rd_addr_r <= '0;
          end
        end
        S_WAIT: begin
          x_r <= mem_output;
        end
        S_CALC: begin
          code_r    <= rq_to_r3(x_r);
          wr_addr_r <= i_r;
        end
        S_WRITE: begin
          if (more) begin
            i_r       <= i_r + AW'(1);
            rd_addr_r <= i_r + AW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rd_addr = rd_addr_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = code_r;

`ifdef RQ2R3_RANGE_CHECK_EN
  logic err_r;
  logic range_bad;

  // err is visible already in the WAIT cycle that sees the bad word, then held.
  assign range_bad = (state == S_WAIT) && ({1'b0, mem_output} >= (DW + 1)'(Q));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      err_r <= 1'b0;
    end else if (range_bad) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r | range_bad;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rq_to_r3_fsm.sv
`timescale 1ns/1ps
module tb_rq_to_r3_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] degp;
  logic        rd_en;
  logic [10:0] rd_addr;
  logic [12:0] mem_output;
  logic        write_enable;
  logic [10:0] wr_addr;
  logic [1:0]  wr_data;
  logic        busy;
  logic        done;
  logic        err;

  rq_to_r3_fsm dut (
    .clk(clk), .rst_n(rst_n), .start(start), .degp(degp),
    .rd_en(rd_en), .rd_addr(rd_addr), .mem_output(mem_output),
    .write_enable(write_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [12:0] ram [0:2047];
  always @(posedge clk) if (rd_en) mem_output <= ram[rd_addr];

  int checks = 0;
  int errors = 0;

  bit mon_on = 1'b0;
  int cyc, busy_cnt, wr_cnt, done_cnt, done_cyc, rd_bad, exp_rd, err_cyc;
  int wa [0:1023];
  int wd [0:1023];
  int wc [0:1023];

  always @(negedge clk) begin
    if (mon_on) begin
      cyc++;
      if (busy) busy_cnt++;
      if (write_enable && wr_cnt < 1024) begin
        wa[wr_cnt] = int'(wr_addr);
        wd[wr_cnt] = int'(wr_data);
        wc[wr_cnt] = cyc;
        wr_cnt++;
      end
      if (rd_en) begin
        if (int'(rd_addr) != exp_rd) rd_bad++;
        exp_rd++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (err && err_cyc < 0) err_cyc = cyc;
    end
  end

  task automatic mon_clear();
    cyc = 0; busy_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1;
    rd_bad = 0; exp_rd = 0; err_cyc = -1;
    wa[0] = -1; wd[0] = -1; wc[0] = -1;
  endtask

  // Cycle 1 of the monitor is the first cycle after the edge that samples start.
  task automatic start_conv(input int d);
    @(posedge clk); #1;
    degp  = 11'(d);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mon_clear();
    mon_on = 1'b1;
  endtask

  function automatic int ref_f(input int x);
    int v;
    v = (x > 2295) ? x - 4591 : x;
    return ((v % 3) + 3) % 3;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; degp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (rd_en !== 1'b0)        begin errors++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    checks++; if (rd_addr !== 11'd0)     begin errors++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_write_enable: got %b want 0", write_enable); end
    checks++; if (wr_addr !== 11'd0)     begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    checks++; if (wr_data !== 2'd0)      begin errors++; $display("FAIL reset_wr_data: got %0d want 0", wr_data); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)         begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0)          begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_values();
    int vals [8] = '{0, 1, 2, 2294, 2295, 2296, 4589, 4590};
    int exps [8] = '{0, 1, 2, 2,    0,    0,    1,    2};
    for (int k = 0; k < 8; k++) begin
      ram[0] = 13'(vals[k]);
      start_conv(0);
      repeat (8) begin @(negedge clk); #1; end
      mon_on = 1'b0;
      checks++; if (wr_cnt != 1)       begin errors++; $display("FAIL single_%0d_wr_count: got %0d want 1", vals[k], wr_cnt); end
      checks++; if (wd[0] != exps[k])  begin errors++; $display("FAIL single_%0d_wr_data: got %0d want %0d", vals[k], wd[0], exps[k]); end
      checks++; if (wa[0] != 0)        begin errors++; $display("FAIL single_%0d_wr_addr: got %0d want 0", vals[k], wa[0]); end
      checks++; if (wc[0] != 4)        begin errors++; $display("FAIL single_%0d_wr_cycle: got T+%0d want T+4", vals[k], wc[0]); end
      checks++; if (done_cyc != 5)     begin errors++; $display("FAIL single_%0d_done_cycle: got T+%0d want T+5", vals[k], done_cyc); end
      checks++; if (done_cnt != 1)     begin errors++; $display("FAIL single_%0d_done_count: got %0d want 1", vals[k], done_cnt); end
    end
  endtask

  task automatic test_full_with_busy_start();
    bit fin = 1'b0;
    int bad;
    for (int i = 0; i < 757; i++) ram[i] = 13'((i * 37) % 4591);
    start_conv(756);
    for (int k = 0; k < 3200 && !fin; k++) begin
      @(negedge clk); #1;
      if (cyc == 9) begin
        start = 1'b1; degp = 11'd3;
      end else if (cyc == 10) begin
        start = 1'b0; degp = 11'd0;
      end
      if (done_cnt > 0) fin = 1'b1;
    end
    mon_on = 1'b0;
    checks++; if (!fin) begin errors++; $display("FAIL full_timeout: done not seen within 3200 cycles"); end
    checks++; if (wr_cnt != 757)    begin errors++; $display("FAIL full_wr_count: got %0d want 757", wr_cnt); end
    bad = 0;
    for (int j = 0; j < wr_cnt && j < 757; j++) begin
      checks++;
      if (wa[j] != j || wd[j] != ref_f((j * 37) % 4591)) begin
        errors++; bad++;
        if (bad <= 10) $display("FAIL full_write_%0d: got addr %0d data %0d want addr %0d data %0d", j, wa[j], wd[j], j, ref_f((j * 37) % 4591));
      end
    end
    checks++; if (rd_bad != 0)      begin errors++; $display("FAIL full_rd_sequence: got %0d out-of-order reads want 0", rd_bad); end
    checks++; if (exp_rd != 757)    begin errors++; $display("FAIL full_rd_count: got %0d want 757", exp_rd); end
    checks++; if (busy_cnt != 3029) begin errors++; $display("FAIL full_busy_cycles: got %0d want 3029", busy_cnt); end
    checks++; if (done_cyc != 3029) begin errors++; $display("FAIL full_done_cycle: got T+%0d want T+3029", done_cyc); end
    checks++; if (done_cnt != 1)    begin errors++; $display("FAIL full_done_count: got %0d want 1", done_cnt); end

    // Restart from the IDLE cycle right after DONE.
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL back_to_back_idle: busy got %b want 0", busy); end
    start = 1'b1; degp = 11'd0;
    @(negedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || rd_en !== 1'b1 || rd_addr !== 11'd0) begin
      errors++; $display("FAIL back_to_back_accept: busy %b rd_en %b rd_addr %0d want 1 1 0", busy, rd_en, rd_addr);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    bit found = 1'b0;
    bit hit101 = 1'b0;
    for (int i = 0; i < 757; i++) ram[i] = 13'((i * 37) % 4591);
    start_conv(756);
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk); #1;
      if (write_enable && wr_addr == 11'd100) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL midreset_timeout: write to 100 not seen"); end
    rst_n = 1'b0;
    @(negedge clk); #1;
    checks++; if ({rd_en, write_enable, busy, done, err} !== 5'b0) begin
      errors++; $display("FAIL midreset_strobes: got rd_en %b we %b busy %b done %b err %b want all 0", rd_en, write_enable, busy, done, err);
    end
    checks++; if (rd_addr !== 11'd0 || wr_addr !== 11'd0 || wr_data !== 2'd0) begin
      errors++; $display("FAIL midreset_regs: got rd_addr %0d wr_addr %0d wr_data %0d want 0 0 0", rd_addr, wr_addr, wr_data);
    end
    rst_n = 1'b1;
    repeat (20) begin @(negedge clk); #1; end
    mon_on = 1'b0;
    for (int j = 0; j < wr_cnt; j++) if (wa[j] == 101) hit101 = 1'b1;
    checks++; if (hit101)         begin errors++; $display("FAIL midreset_no_write_101: got a write to 101 want none"); end
    checks++; if (wr_cnt != 101)  begin errors++; $display("FAIL midreset_wr_count: got %0d want 101", wr_cnt); end
    checks++; if (done_cnt != 0)  begin errors++; $display("FAIL midreset_no_done: got %0d done pulses want 0", done_cnt); end

    start_conv(2);
    repeat (14) begin @(negedge clk); #1; end
    mon_on = 1'b0;
    checks++; if (wr_cnt != 3 || wa[0] != 0) begin errors++; $display("FAIL restart_writes: got count %0d first addr %0d want 3 0", wr_cnt, wa[0]); end
    checks++; if (rd_bad != 0)    begin errors++; $display("FAIL restart_rd_sequence: got %0d bad reads want 0", rd_bad); end
    checks++; if (done_cnt != 1)  begin errors++; $display("FAIL restart_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_range_check();
    int vals [6] = '{10, 20, 30, 4591, 2300, 4000};
    int exps [6] = '{1,  2,  0,  0,    1,    0};
    bit fin = 1'b0;
    logic err_after;
    for (int j = 0; j < 6; j++) ram[j] = 13'(vals[j]);
    start_conv(5);
    for (int k = 0; k < 60 && !fin; k++) begin
      @(negedge clk); #1;
      if (done_cnt > 0) fin = 1'b1;
    end
    @(negedge clk); #1;
    err_after = err;
    mon_on = 1'b0;
    checks++; if (!fin)        begin errors++; $display("FAIL range_timeout: done not seen"); end
    checks++; if (wr_cnt != 6) begin errors++; $display("FAIL range_wr_count: got %0d want 6", wr_cnt); end
    for (int j = 0; j < 6 && j < wr_cnt; j++) begin
      checks++; if (wd[j] != exps[j]) begin errors++; $display("FAIL range_wr_data_%0d: got %0d want %0d", j, wd[j], exps[j]); end
    end
`ifdef RQ2R3_RANGE_CHECK_EN
    checks++; if (err_cyc != 14)     begin errors++; $display("FAIL range_err_rise: got T+%0d want T+14", err_cyc); end
    checks++; if (err_after !== 1'b1) begin errors++; $display("FAIL range_err_sticky: got %b want 1", err_after); end
`else
    checks++; if (err_cyc != -1)     begin errors++; $display("FAIL range_err_tied: rose at T+%0d want never", err_cyc); end
    checks++; if (err_after !== 1'b0) begin errors++; $display("FAIL range_err_after: got %b want 0", err_after); end
`endif
  endtask

  initial begin
    start = 1'b0; degp = '0; rst_n = 1'b0;
    test_reset();
    test_single_values();
    test_full_with_busy_start();
    test_reset_mid_run();
    test_range_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
